// File: rtl/array_sum_engine_pkg.sv
// Shared types and constants for the array sum engine.
package array_sum_engine_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_LEN,
    RD_ELEM,
    WR_SUM,
    DONE
  } state_e;

  localparam int WORD_W      = 32;
  localparam int MAX_LEN_DEF = 16;

endpackage

// File: rtl/array_sum_engine.sv
// Memory-side initiator: reads a length word and that many elements, then
// writes their 32-bit sum back to a destination address.
module array_sum_engine
  import array_sum_engine_pkg::*;
#(
  parameter int Addr_W  = 8,
  parameter int byte_W  = 4,
  parameter int MAX_LEN = MAX_LEN_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [Addr_W-1:0]     base_addr,
  input  logic [Addr_W-1:0]     dest_addr,
  output logic [Addr_W-1:0]     mem_address,
  output logic [8*byte_W-1:0]   mem_write_data,
  output logic                  mem_write_enable,
  input  logic [8*byte_W-1:0]   mem_read_data,
  output logic                  busy,
  output logic                  done,
  output logic [8*byte_W-1:0]   result,
  output logic                  overflow,
  output logic                  len_err
);

  localparam int DW = 8 * byte_W;
  localparam int CW = $clog2(MAX_LEN + 1);
  localparam logic [Addr_W-1:0] STRIDE = Addr_W'(byte_W);

  state_e            state_q, state_d;
  logic [Addr_W-1:0] addr_q, addr_d;
  logic [Addr_W-1:0] dest_q, dest_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [DW-1:0]     acc_q, acc_d;
  logic [CW-1:0]     len_q, len_d;
  logic [CW-1:0]     idx_q, idx_d;
  logic [DW-1:0]     result_q, result_d;
  logic              ovf_q, ovf_d;
  logic              lerr_q, lerr_d;
  logic [DW:0]       sum;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    dest_d   = dest_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    acc_d    = acc_q;
    len_d    = len_q;
    idx_d    = idx_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    lerr_d   = lerr_q;
    sum      = {1'b0, acc_q} + {1'b0, mem_read_data};

    case (state_q)
      IDLE: begin
        if (start) begin
          dest_d  = dest_addr;
          addr_d  = base_addr;
          acc_d   = '0;
          idx_d   = '0;
          ovf_d   = 1'b0;
          lerr_d  = 1'b0;
          state_d = RD_LEN;
        end
      end
      RD_LEN: begin
        // mem_address still holds the base here, so the first element is one stride on
        if (mem_read_data > DW'(MAX_LEN)) begin
          lerr_d = 1'b1;
          len_d  = CW'(MAX_LEN);
        end else begin
          len_d  = CW'(mem_read_data);
        end
        if (mem_read_data == '0) begin
          wdata_d = '0;
          addr_d  = dest_q;
          we_d    = 1'b1;
          state_d = WR_SUM;
        end else begin
          addr_d  = addr_q + STRIDE;
          state_d = RD_ELEM;
        end
      end
      RD_ELEM: begin
        acc_d = sum[DW-1:0];
        ovf_d = ovf_q | sum[DW];
        if (idx_q == len_q - CW'(1)) begin
          wdata_d = sum[DW-1:0];
          addr_d  = dest_q;
          we_d    = 1'b1;
          state_d = WR_SUM;
        end else begin
          idx_d  = idx_q + CW'(1);
          addr_d = addr_q + STRIDE;
        end
      end
      WR_SUM: begin
        we_d     = 1'b0;
        result_d = wdata_q;
        state_d  = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      dest_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      acc_q    <= '0;
      len_q    <= '0;
      idx_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      lerr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      dest_q   <= dest_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      acc_q    <= acc_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      lerr_q   <= lerr_d;
    end
  end

  assign mem_address      = addr_q;
  assign mem_write_data   = wdata_q;
  assign mem_write_enable = we_q;
  assign busy             = (state_q != IDLE);
  assign done             = (state_q == DONE);
  assign result           = result_q;
  assign overflow         = ovf_q;
  assign len_err          = lerr_q;

endmodule

// File: doc/array_sum_engine.md
# array_sum_engine

Memory-side initiator for the byte-addressed, little-endian data memory. On a start pulse it reads a length word at a base address and then that many 32-bit elements that follow it. It accumulates their sum and writes the 32-bit result back to a destination address. It sits between the control logic and the data memory port, and owns that port while busy.

## Interface
- `Addr_W`, 8, memory byte-address width; all address arithmetic wraps modulo 2^Addr_W.
- `byte_W`, 4, bytes per word; the element stride is `byte_W`.
- `MAX_LEN`, 16, largest accepted element count.
- `clk` input 1: single clock; all state changes occur on its rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `start` input 1: one-cycle request; sampled only in IDLE.
- `base_addr` input Addr_W: address of the length word; captured with `start`.
- `dest_addr` input Addr_W: address for the result write; captured with `start`.
- `mem_address` output Addr_W: registered memory address.
- `mem_write_data` output 8*byte_W: registered write data.
- `mem_write_enable` output 1: registered write strobe.
- `mem_read_data` input 8*byte_W: combinational read data for `mem_address`, valid in the same cycle.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle completion pulse.
- `result` output 8*byte_W: last sum, held until the next completion.
- `overflow` output 1: set if any addition carried out of bit 31; valid with `done`.
- `len_err` output 1: set if the length word exceeded `MAX_LEN`; valid with `done`.

## Operation
- Reset value of every output is 0.
- States are IDLE, RD_LEN, RD_ELEM, WR_SUM and DONE.
- **IDLE, start high:** capture `base_addr` and `dest_addr`. Clear the accumulator, index, `overflow` and `len_err`. Set `mem_address=base_addr`. Go to RD_LEN.
- **RD_LEN:** latch the length L = `mem_read_data`.
  - If L > `MAX_LEN`: set `len_err` and use L = `MAX_LEN`.
  - If L = 0: load `mem_write_data=0` and `mem_address=dest_addr`, assert `mem_write_enable`, go to WR_SUM.
  - Otherwise: set `mem_address=base+byte_W`, go to RD_ELEM.
- **RD_ELEM, each cycle:** compute acc' = acc + `mem_read_data` (32-bit wrap) and OR the carry into `overflow`.
  - If the index is not L-1: increment the index, advance `mem_address` by `byte_W`, stay in RD_ELEM.
  - If the index is L-1: load `mem_write_data=acc'` and `mem_address=dest_addr`, assert `mem_write_enable`, go to WR_SUM.
- **WR_SUM:** the memory commits the write on the edge that ends this cycle. On that edge, deassert `mem_write_enable`, load `result`, go to DONE.
- **DONE:** `done=1` for exactly one cycle, then return to IDLE. `done` is high only in DONE.
- `start` outside IDLE is ignored; there is no queueing.
- `mem_write_enable` is high only in WR_SUM, for exactly one cycle per operation.
- Address wrap: an element address past 2^Addr_W-1 wraps to 0. A destination that overlaps the source is allowed, because the write happens after all reads.
- Reset mid-operation: outputs clear immediately, memory is never written, and `result` returns to 0.

## Timing
- For L elements (L ≥ 1), take the start edge as E0:
  - RD_LEN occupies cycle 1.
  - RD_ELEM occupies cycles 2 to L+1.
  - WR_SUM occupies cycle L+2.
  - `done` is high in cycle L+3.
- L = 0: `done` in cycle 3.
- The next `start` is accepted in the cycle after `done`, so the back-to-back period is L+4 cycles.
- Read data is consumed in the same cycle its address is presented; there is no memory wait state.

## Structure
- Shared package holds:
  - the state enum;
  - `WORD_W = 32`;
  - the `MAX_LEN` default.
- No sub-module. The counter, accumulator and FSM form one block of about 150–250 lines.

## Test plan
- Memory has word 20 = 3 and words 24/28/32 = 5/7/9. Apply `start` with base=20, dest=40 -> `done` at E0+6; memory word 40 = 0x15; `result` = 0x15; `overflow` = 0; `len_err` = 0.
- Length word = 0 at base 0 -> `done` at E0+3; word at dest = 0; no element reads issued.
- Elements 0xFFFFFFFF and 0x2 -> `result` = 0x1; `overflow` = 1.
- Length word = 40 with `MAX_LEN` = 16 -> exactly 16 elements summed; `len_err` = 1; `done` at E0+19.
- Base = 248 with L = 3 (Addr_W = 8) -> element reads at 252, 0, 4 (wrap-around); the sum is correct.
- Deassert `rst_n` during RD_ELEM -> outputs 0 asynchronously and the destination word is unchanged. Reissued `start` -> correct result. `start` pulses while busy -> ignored.
